// File: rtl/lshift16_arb_if.sv
// Bundles the two request ports, the result port and the grant counters
// of the shared 16-bit left-shift arbiter.
interface lshift16_arb_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [15:0]      req0_a;
  logic [3:0]       req0_shl;
  logic             req0_ready;
  logic             req1_valid;
  logic [15:0]      req1_a;
  logic [3:0]       req1_shl;
  logic             req1_ready;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] gnt0_cnt;
  logic [CNT_W-1:0] gnt1_cnt;

  modport master (
    output req0_valid, req0_a, req0_shl, req1_valid, req1_a, req1_shl, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, gnt0_cnt, gnt1_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_shl, req1_valid, req1_a, req1_shl, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, gnt0_cnt, gnt1_cnt
  );
endinterface

// File: rtl/lshift16_arb.sv
// Two-port round-robin arbiter in front of one shared 16-bit left shifter,
// with a single-entry result register and saturating per-port grant counters.
module lshift16_arb #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  lshift16_arb_if.slave bus
);
  logic             can_accept_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic [15:0]      op_a_s;
  logic [3:0]       op_shl_s;
  logic [15:0]      shift_s;
  logic             out_valid_r;
  logic [15:0]      out_data_r;
  logic             out_src_r;
  logic             prio_r;
  logic [CNT_W-1:0] gnt0_cnt_r;
  logic [CNT_W-1:0] gnt1_cnt_r;

  function automatic logic [15:0] shl16(input logic [15:0] a, input logic [3:0] n);
    return a << n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // A full result register can still take a new operation in the cycle it drains.
  assign can_accept_s = !out_valid_r || bus.out_ready;

  // Grant selection: prio_r names the port that wins a tie (0 or 1).
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (prio_r) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (bus.req0_valid) begin
      gnt0_s = 1'b1;
    end else if (bus.req1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // rst_n gates ready so nothing is offered while reset is held.
  assign ready0_s = rst_n && can_accept_s && gnt0_s;
  assign ready1_s = rst_n && can_accept_s && gnt1_s;
  assign accept_s = ready0_s || ready1_s;

  // Operand mux into the single shared shifter.
  always_comb begin
    op_a_s   = 16'h0000;
    op_shl_s = 4'd0;
    if (gnt1_s) begin
      op_a_s   = bus.req1_a;
      op_shl_s = bus.req1_shl;
    end else begin
      op_a_s   = bus.req0_a;
      op_shl_s = bus.req0_shl;
    end
  end

  assign shift_s = shl16(op_a_s, op_shl_s);

  // Result register, round-robin pointer and grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      out_src_r   <= 1'b0;
      prio_r      <= 1'b0;
      gnt0_cnt_r  <= {CNT_W{1'b0}};
      gnt1_cnt_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= shift_s;
      out_src_r   <= gnt1_s;
      prio_r      <= gnt0_s;
      if (gnt0_s) begin
        gnt0_cnt_r <= sat_inc(gnt0_cnt_r);
      end else begin
        gnt1_cnt_r <= sat_inc(gnt1_cnt_r);
      end
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_src    = out_src_r;
  assign bus.gnt0_cnt   = gnt0_cnt_r;
  assign bus.gnt1_cnt   = gnt1_cnt_r;
endmodule

// File: doc/lshift16_arb.md
LSHIFT16_ARB -- requirements
Module: lshift16_arb

Interface
REQ-001 Parameter: CNT_W, default 8, width of the per-port grant counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  port 0 has an operation pending.
REQ-005 req0_a  input  16  port 0 operand.
REQ-006 req0_shl  input  4  port 0 left-shift amount, 0..15.
REQ-007 req0_ready  output  1  port 0 operation accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_a[15:0], req1_shl[3:0], req1_ready  carry the same meaning for port 1.
REQ-009 out_valid  output  1  result register holds a result.
REQ-010 out_data  output  16  shifted result.
REQ-011 out_src  output  1  port that issued out_data (0 or 1).
REQ-012 out_ready  input  1  consumer takes the result when high with out_valid.
REQ-013 gnt0_cnt, gnt1_cnt  output  CNT_W  accepted-operation counts per port.

Function
REQ-014 The block SHALL share one 16-bit combinational left shifter between ports 0 and 1.
REQ-015 Shift result SHALL be (a << shl) truncated to 16 bits; vacated LSBs are zero, bits shifted past bit 15 are lost.
REQ-016 can_accept SHALL be (!out_valid || out_ready), so a full register accepts a new operation in the same cycle it drains.
REQ-017 Grant: one valid port is granted; with both valid, the port holding priority is granted; with none valid, no grant.
REQ-018 Priority SHALL be a 1-bit round-robin pointer; after each accepted operation it points to the port not granted.
REQ-019 Priority SHALL NOT change in cycles without an accepted operation.
REQ-020 reqN_ready SHALL be can_accept && grantN; at most one ready is high per cycle; ready may depend combinationally on valid.
REQ-021 On acceptance, out_data, out_src and out_valid=1 SHALL be registered on that edge (latency 1 cycle, throughput 1 per cycle).
REQ-022 While out_valid && !out_ready, out_data and out_src SHALL hold stable and both readys SHALL be low.
REQ-023 If out_valid && out_ready with no acceptance, out_valid SHALL clear on the next edge.
REQ-024 gntN_cnt SHALL increment by 1 on each port-N acceptance and saturate at 2^CNT_W-1 (no wrap).
REQ-025 Inputs of a non-granted port SHALL have no effect; a port dropping valid before acceptance is legal.

Reset
REQ-026 While rst_n is low: out_valid=0, out_data=16'h0000, out_src=0, priority=port 0, gnt0_cnt=gnt1_cnt=0, all readys low.
REQ-027 Assertion of rst_n mid-operation SHALL immediately discard any held result, with no partial output.
REQ-028 After rst_n deasserts, the first edge SHALL accept normally.

Verification
REQ-029 Port 0 only, a=16'h0003, shl=4, out_ready=1 -> next cycle out_valid=1, out_data=16'h0030, out_src=0, gnt0_cnt=1.
REQ-030 Both valid every cycle, out_ready=1 (port 0: 16'h0001/shl 1; port 1: 16'h8001/shl 1) -> outputs alternate 16'h0002/src0, 16'h0002/src1, starting with port 0 after reset.
REQ-031 Overflow and bounds: a=16'hFFFF, shl=15 -> 16'h8000; a=16'h1234, shl=0 -> 16'h1234.
REQ-032 Result 16'h0030 held with out_ready=0 for 3 cycles and both ports valid -> out_data stable, readys low, priority unchanged; on out_ready=1, the next result is accepted in that same cycle.
REQ-033 Port 1 streams 300 operations with CNT_W=8 -> gnt1_cnt saturates at 8'hFF.
REQ-034 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately; all counters and priority return to reset values.
